// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset request sequencer and its helpers.
// Holds the sequencer state encoding and the default parameter values so
// that every always-on block agrees on them.
package rst_seq_pkg;

  localparam int STRETCH_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF    = 3;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  // ASSERT is the all-zero encoding so the reset state is also the
  // power-on sequence entry point.
  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_WAIT_HI = 2'd1,
    ST_RELEASE = 2'd2,
    ST_IDLE    = 2'd3
  } rst_seq_state_e;

endpackage

// File: rtl/rst_ack_sync.sv
// Single-bit multi-flop synchronizer for feedback signals (e.g. a target
// domain's synchronized reset) that are asynchronous to the always-on clock.
// Ports:
//   clock, reset : always-on clock, async active-high reset (flops clear to 0)
//   d            : asynchronous input
//   q            : d delayed by SYNC_STAGES clock edges
module rst_ack_sync
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_request_sequencer.sv
// Initiator side of a target-domain reset handshake. Accepts reset requests,
// drives a stretched reset into the target, waits for the target's
// synchronized reset to come back asserted and then released, and reports
// completion (done) or timeout (err). Reset itself starts a power-on sequence.
// Ports:
//   clock, reset : always-on clock, async active-high reset
//   req_valid    : reset request, held until accepted
//   req_ready    : high in IDLE only
//   rst_out      : registered reset to the target's synchronizer
//   tgt_ack      : target's synchronized reset, asynchronous feedback
//   busy         : high in every state except IDLE
//   done, err    : single-cycle completion / timeout pulses
module reset_request_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  output logic rst_out,
  input  logic tgt_ack,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int CNT_MAX = (STRETCH_CYCLES > TIMEOUT_CYCLES) ? STRETCH_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  rst_seq_state_e state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           done_nx, err_nx;
  logic           ack_s;

  rst_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clock (clock),
    .reset (reset),
    .d     (tgt_ack),
    .q     (ack_s)
  );

  // The counter is cleared on every state change, so it only has to span
  // the longer of the stretch and timeout windows and never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      ST_ASSERT: begin
        if (cnt == STRETCH_LAST) begin
          state_nx = ST_WAIT_HI;
          cnt_nx   = '0;
        end
      end
      ST_WAIT_HI: begin
        // ack is tested first so a same-cycle ack beats the timeout
        if (ack_s) begin
          state_nx = ST_RELEASE;
          cnt_nx   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          err_nx   = 1'b1;
          state_nx = ST_RELEASE;
          cnt_nx   = '0;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          err_nx   = 1'b1;
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      ST_IDLE: begin
        cnt_nx = '0;
        if (req_valid) state_nx = ST_ASSERT;
      end
      default: begin
        state_nx = ST_ASSERT;
        cnt_nx   = '0;
      end
    endcase
  end

  // rst_out is registered from the next state so it is glitch-free toward
  // the target and still tracks ASSERT/WAIT_HI exactly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_ASSERT;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rst_out <= 1'b1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      done    <= done_nx;
      err     <= err_nx;
      rst_out <= (state_nx == ST_ASSERT) || (state_nx == ST_WAIT_HI);
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Self-checking bench for reset_request_sequencer: directed scenarios plus a
// randomized phase, compared every cycle against a phase/elapsed-time model.
module tb_reset_request_sequencer;

  localparam int STRETCH = 16;
  localparam int SYNC    = 3;
  localparam int TMO     = 64;

  localparam int P_ASSERT = 0;
  localparam int P_WAIT   = 1;
  localparam int P_REL    = 2;
  localparam int P_IDLE   = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic tgt_ack = 1'b0;
  logic req_ready, rst_out, busy, done, err;

  reset_request_sequencer #(
    .STRETCH_CYCLES(STRETCH),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rst_out  (rst_out),
    .tgt_ack  (tgt_ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: current phase, edge at which it was entered, pulses
  int m_ph = P_ASSERT;
  int m_t0 = 0;
  bit m_done = 1'b0;
  bit m_err  = 1'b0;
  int m_dones = 0;
  int dut_dones = 0;
  int dut_errs = 0;
  bit ack_q[$];          // tgt_ack samples of the last SYNC edges, oldest first

  // target environment: 0 follow rst_out with delay dly, 1 low, 2 high, 3 random
  int mode = 0;
  int dly = 3;
  logic [7:0] rhist = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ph = P_ASSERT;
    m_t0 = cyc;
    m_done = 1'b0;
    m_err = 1'b0;
    ack_q.delete();
    for (int i = 0; i < SYNC; i++) ack_q.push_back(1'b0);
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    m_t0 = cyc;
  endtask

  // a: synchronized ack visible before this edge, r: req_valid before it
  task automatic model_edge(input bit a, input bit r);
    int el;
    el = cyc - m_t0;   // cycles already spent in the current phase
    m_done = 1'b0;
    m_err = 1'b0;
    case (m_ph)
      P_ASSERT: if (el == STRETCH) enter(P_WAIT);
      P_WAIT: begin
        if (a) enter(P_REL);
        else if (el == TMO) begin m_err = 1'b1; enter(P_REL); end
      end
      P_REL: begin
        if (!a) begin m_done = 1'b1; enter(P_IDLE); end
        else if (el == TMO) begin m_err = 1'b1; m_done = 1'b1; enter(P_IDLE); end
      end
      default: if (r) enter(P_ASSERT);
    endcase
    if (m_done) m_dones++;
  endtask

  task automatic step();
    bit a;
    a = ack_q[0];
    @(posedge clock);
    cyc++;
    void'(ack_q.pop_front());
    ack_q.push_back(tgt_ack);
    if (reset) model_reset();
    else model_edge(a, req_valid);
    #1;
    chk("rst_out", {31'd0, rst_out}, {31'd0, (m_ph == P_ASSERT) || (m_ph == P_WAIT)});
    chk("req_ready", {31'd0, req_ready}, {31'd0, m_ph == P_IDLE});
    chk("busy", {31'd0, busy}, {31'd0, m_ph != P_IDLE});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (done === 1'b1) dut_dones++;
    if (err === 1'b1) dut_errs++;
    rhist = {rhist[6:0], rst_out};
    case (mode)
      0: tgt_ack = rhist[dly-1];
      1: tgt_ack = 1'b0;
      2: tgt_ack = 1'b1;
      default: tgt_ack = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_done(input string tag, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      step();
      if (done === 1'b1) got = 1'b1;
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic request_pulse();
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi_cnt, k, k2, d0, e0, idle_cnt;
    bit got;
    model_reset();

    // reset state, with the target following rst_out
    mode = 0; dly = 3;
    repeat (4) step();

    // power-on sequence after release
    reset = 1'b0;
    chk("por_rst_at_release", {31'd0, rst_out}, 32'd1);
    hi_cnt = 1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      step();
      if (rst_out === 1'b1) hi_cnt++; else got = 1'b1;
    end
    chk("por_rst_fell", {31'd0, got}, 32'd1);
    chk("por_hi_len_ge_17", {31'd0, hi_cnt >= STRETCH + 1}, 32'd1);
    wait_done("por", 200);
    chk("por_ready_at_done", {31'd0, req_ready}, 32'd1);

    // single requests from IDLE with varied target latency
    for (int n = 0; n < 3; n++) begin
      dly = $urandom_range(1, 6);
      repeat ($urandom_range(0, 5)) step();
      d0 = dut_dones;
      request_pulse();
      chk("req_rst_next", {31'd0, rst_out}, 32'd1);
      chk("req_busy_next", {31'd0, busy}, 32'd1);
      wait_done("req", 200);
      repeat (5) step();
      chk("req_one_done", dut_dones - d0, 32'd1);
    end

    // stuck-low ack: WAIT_HI times out after TMO cycles
    mode = 1;
    repeat (4) step();
    request_pulse();
    k = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      k++;
      if (err === 1'b1) got = 1'b1;
    end
    chk("lo_err_seen", {31'd0, got}, 32'd1);
    chk("lo_err_latency", k, STRETCH + TMO);
    chk("lo_rst_low_in_release", {31'd0, rst_out}, 32'd0);
    step();
    chk("lo_done_after", {31'd0, done}, 32'd1);
    chk("lo_idle_after", {31'd0, req_ready}, 32'd1);

    // stuck-high ack: RELEASE times out, err and done together
    mode = 2;
    repeat (5) step();
    request_pulse();
    k2 = 0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (busy === 1'b1 && rst_out === 1'b0) k2++;
      if (done === 1'b1) got = 1'b1;
    end
    chk("hi_done_seen", {31'd0, got}, 32'd1);
    chk("hi_err_with_done", {31'd0, err}, 32'd1);
    chk("hi_release_len", k2, TMO);

    // back-to-back requests with req_valid held
    mode = 0; dly = 3;
    repeat (6) step();
    d0 = dut_dones;
    idle_cnt = 0;
    req_valid = 1'b1;
    for (int i = 0; i < 600 && (dut_dones - d0) < 3; i++) begin
      step();
      if (req_ready === 1'b1) idle_cnt++;
    end
    req_valid = 1'b0;
    chk("b2b_dones", dut_dones - d0, 32'd3);
    chk("b2b_idle_cycles", idle_cnt, 32'd3);
    step();
    chk("b2b_final_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of WAIT_HI
    mode = 1;
    repeat (4) step();
    request_pulse();
    repeat (STRETCH + 10) step();
    e0 = dut_errs;
    d0 = dut_dones;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_async_rst_out", {31'd0, rst_out}, 32'd1);
    chk("mid_rst_async_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_async_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_no_done", {31'd0, done}, 32'd0);
    chk("mid_rst_no_err", {31'd0, err}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    mode = 0; dly = 3;
    wait_done("mid_rst_restart", 200);
    chk("mid_rst_no_err_total", dut_errs - e0, 32'd0);
    chk("mid_rst_one_done", dut_dones - d0, 32'd1);

    // reset in IDLE while done is high: rst_out rises, done dropped
    repeat (3) step();
    request_pulse();
    wait_done("idle_rst_setup", 200);
    #2 reset = 1'b1;
    #1;
    chk("idle_rst_async_rst_out", {31'd0, rst_out}, 32'd1);
    chk("idle_rst_done_dropped", {31'd0, done}, 32'd0);
    repeat (2) step();
    reset = 1'b0;
    wait_done("idle_rst_restart", 200);

    // randomized traffic and target behaviour
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        mode = $urandom_range(0, 3);
        dly = $urandom_range(1, 6);
      end
      req_valid = 1'($urandom_range(0, 3) == 0);
      step();
    end
    req_valid = 1'b0;
    mode = 0; dly = 3;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (req_ready === 1'b1) got = 1'b1;
    end
    chk("rand_settle_idle", {31'd0, got}, 32'd1);
    chk("done_total", dut_dones, m_dones);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
